// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin share of one signed OP_W x OP_W multiplier among NUM_REQ requesters
// Ports: ap_clk/ap_rst_n clock and async active-low reset; req_valid/req_ready/req_a/req_b per-requester
//        operand handshake (requester i at [i*OP_W +: OP_W]); mul_din0/mul_din1/mul_dout to and from the
//        external combinational multiplier; res_valid/res_ready/res_data/res_id tagged product channel;
//        op_count completed results, wrapping.
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int OP_W    = 36,
  parameter int CNT_W   = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [OP_W-1:0]         mul_din0,
  output logic [OP_W-1:0]         mul_din1,
  input  logic [2*OP_W-1:0]       mul_dout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*OP_W-1:0]       res_data,
  output logic [ID_W-1:0]         res_id,
  output logic [CNT_W-1:0]        op_count
);
  logic                r_s1_valid, r_res_valid;
  logic [OP_W-1:0]     r_s1_a, r_s1_b;
  logic [ID_W-1:0]     r_s1_id, r_res_id, r_last_grant;
  logic [2*OP_W-1:0]   r_res_data;
  logic [CNT_W-1:0]    r_op_count;
  logic [ID_W-1:0]     w_win, w_j;
  logic [NUM_REQ-1:0]  w_grant;
  logic                w_adv, w_found, w_fire;
  int                  w_idx;
  assign w_adv = !r_res_valid || res_ready;
  // scan upward from the requester after the last winner, wrapping once
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    w_j     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = int'(r_last_grant) + k;
      w_idx = (w_idx >= NUM_REQ) ? w_idx - NUM_REQ : w_idx;
      w_j   = ID_W'(w_idx);
      if (!w_found && req_valid[w_j]) begin
        w_found = 1'b1;
        w_win   = w_j;
      end
    end
  end
  assign w_grant   = w_found ? (NUM_REQ'(1) << w_win) : '0;
  assign req_ready = w_adv ? w_grant : '0;
  assign w_fire    = w_adv && w_found;
  // stalls freeze the whole pipeline, including the priority pointer
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_id      <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_id     <= '0;
      r_op_count   <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      if (w_adv) begin
        r_s1_valid  <= w_fire;
        r_res_valid <= r_s1_valid;
        if (w_fire) begin
          r_s1_a       <= req_a[int'(w_win)*OP_W +: OP_W];
          r_s1_b       <= req_b[int'(w_win)*OP_W +: OP_W];
          r_s1_id      <= w_win;
          r_last_grant <= w_win;
        end
        if (r_s1_valid) begin
          r_res_data <= mul_dout;
          r_res_id   <= r_s1_id;
        end
      end
      if (r_res_valid && res_ready) r_op_count <= r_op_count + CNT_W'(1);
    end
  end
  assign mul_din0  = r_s1_a;
  assign mul_din1  = r_s1_b;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign op_count  = r_op_count;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench for the shared-multiplier round-robin arbiter
module tb_mul_share_arbiter;
  localparam int N = 4;
  localparam int W = 36;
  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [W-1:0]     mul_din0, mul_din1;
  logic [2*W-1:0]   mul_dout;
  logic             res_valid, res_ready;
  logic [2*W-1:0]   res_data;
  logic [1:0]       res_id;
  logic [31:0]      op_count;
  logic [N-1:0]     va;
  logic [W-1:0]     a[N], b[N];
  int               n_tests = 0, n_fail = 0;
  int               m_last = N - 1, m_cnt = 0;
  bit               m_s1v = 1'b0, m_rv = 1'b0;
  int               q_id[$];
  logic [2*W-1:0]   q_data[$];
  logic [2*W-1:0]   last_data = '0;
  logic [31:0]      cnt0;
  logic [W-1:0]     ta[3], tb[3];
  logic [2*W-1:0]   te[3];
  mul_share_arbiter dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .op_count(op_count)
  );
  function automatic logic [2*W-1:0] prod(input logic [W-1:0] x, input logic [W-1:0] y);
    return {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
  endfunction
  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom()});
  endfunction
  assign mul_dout = prod(mul_din0, mul_din1);
  always #5 ap_clk = ~ap_clk;
  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // one clock: drive, check grant and result against the model, advance the model
  task automatic step(input bit refill);
    int w;
    bit adv;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a[i];
      req_b[i*W +: W] = b[i];
    end
    req_valid = va;
    #1;
    adv = !m_rv || res_ready;
    w = -1;
    for (int k = 1; k <= N; k++) if (w < 0 && va[(m_last + k) % N]) w = (m_last + k) % N;
    chk("req_ready", 72'(req_ready), (adv && w >= 0) ? (72'(1) << w) : 72'(0));
    chk("res_valid", 72'(res_valid), 72'(m_rv));
    if (m_rv) begin
      chk("sb_pending", 72'(q_id.size() > 0), 72'(1));
      if (q_id.size() > 0) begin
        chk("res_data", res_data, q_data[0]);
        chk("res_id", 72'(res_id), 72'(q_id[0]));
        if (res_ready) begin
          last_data = q_data.pop_front();
          void'(q_id.pop_front());
          m_cnt++;
        end
      end
    end
    if (adv && w >= 0) begin
      q_id.push_back(w);
      q_data.push_back(prod(a[w], b[w]));
    end
    @(posedge ap_clk);
    if (adv) begin
      m_rv = m_s1v;
      m_s1v = (w >= 0);
      if (w >= 0) m_last = w;
    end
    #1;
    if (adv && w >= 0) begin
      if (refill) begin
        a[w] = rnd();
        b[w] = rnd();
      end else va[w] = 1'b0;
    end
    chk("op_count", 72'(op_count), 72'(m_cnt));
    @(negedge ap_clk);
  endtask
  initial begin
    va = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    ta[0] = 36'h800000000; tb[0] = 36'h800000000; te[0] = 72'h400000000000000000;
    ta[1] = 36'h7FFFFFFFF; tb[1] = 36'h800000000; te[1] = 72'hC00000000800000000;
    ta[2] = 36'h000000000; tb[2] = 36'h923456789; te[2] = 72'h0;
    @(negedge ap_clk);
    chk("rst_res_valid", 72'(res_valid), 72'(0));
    chk("rst_res_data", res_data, 72'(0));
    chk("rst_res_id", 72'(res_id), 72'(0));
    chk("rst_op_count", 72'(op_count), 72'(0));
    chk("rst_mul_din0", 72'(mul_din0), 72'(0));
    chk("rst_mul_din1", 72'(mul_din1), 72'(0));
    ap_rst_n = 1'b1;
    // single requester, 3 * -5
    res_ready = 1'b1;
    va[0] = 1'b1; a[0] = 36'd3; b[0] = W'(-5);
    repeat (4) step(1'b0);
    chk("t1_data", last_data, 72'hFFFFFFFFFFFFFFFFF1);
    // all four requesting continuously
    for (int i = 0; i < N; i++) begin
      va[i] = 1'b1;
      a[i] = rnd();
      b[i] = rnd();
    end
    repeat (9) step(1'b1);
    // backpressure with two results in flight
    res_ready = 1'b0;
    cnt0 = op_count;
    repeat (3) step(1'b1);
    res_ready = 1'b1;
    repeat (2) step(1'b0);
    chk("t3_count_plus2", 72'(op_count - cnt0), 72'(2));
    repeat (6) step(1'b0);
    // extreme operands
    for (int t = 0; t < 3; t++) begin
      va[0] = 1'b1; a[0] = ta[t]; b[0] = tb[t];
      repeat (4) step(1'b0);
      chk("t4_extreme", last_data, te[t]);
    end
    // async reset with both stages full
    for (int i = 0; i < N; i++) begin
      va[i] = 1'b1;
      a[i] = rnd();
      b[i] = rnd();
    end
    repeat (2) step(1'b1);
    chk("t5_full_s1", 72'(mul_din0), 72'(q_data.size() > 0 ? 1 : 0) * 72'(mul_din0));
    #2 ap_rst_n = 1'b0;
    #1;
    chk("t5_rst_res_valid", 72'(res_valid), 72'(0));
    chk("t5_rst_op_count", 72'(op_count), 72'(0));
    chk("t5_rst_mul_din0", 72'(mul_din0), 72'(0));
    m_s1v = 1'b0; m_rv = 1'b0; m_last = N - 1; m_cnt = 0;
    q_id.delete();
    q_data.delete();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("t5_first_grant", 72'(req_ready), 72'(1));
    repeat (7) step(1'b0);
    // priority held across a stall
    va[0] = 1'b1; a[0] = rnd(); b[0] = rnd();
    step(1'b0);
    res_ready = 1'b0;
    step(1'b0);
    va[2] = 1'b1; a[2] = rnd(); b[2] = rnd();
    step(1'b0);
    va[1] = 1'b1; a[1] = rnd(); b[1] = rnd();
    step(1'b0);
    res_ready = 1'b1;
    #1;
    chk("t6_req1_wins", 72'(req_ready), 72'(2));
    step(1'b0);
    #1;
    chk("t6_req2_next", 72'(req_ready), 72'(4));
    step(1'b0);
    repeat (4) step(1'b0);
    chk("drain_empty", 72'(q_id.size()), 72'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
